// File: rtl/exe_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : exe_stage_pkg                                              |
// | Brief   : EX stage types: input record, ALU/M opcodes, mul-div FSM.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package exe_stage_pkg;

  // Bit 4 marks an M-extension op; within M ops bit 2 = divide family,
  // bit 1 = remainder, bit 0 = unsigned (for divide).
  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [31:0] store_data;
    alu_op_e     alu_op;
    logic        rf_en;
    logic        dm_en;
    logic [1:0]  wb_sel;
  } exe_stage_in_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_muldiv(input alu_op_e op);
    return op[4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mem_stage_pkg                                              |
// | Brief   : Interface record handed from EX/MEM into the MEM stage.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mem_stage_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] opr_b;    // store data for the MEM stage
    logic [31:0] opr_res;  // ALU / mul-div result or memory address
    logic        rf_en;
    logic        dm_en;
    logic [1:0]  wb_sel;
  } mem_stage_in_t;

endpackage
`default_nettype wire

// File: rtl/exe_stage_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : muldiv_unit                                                |
// | Brief   : Iterative shift-add multiplier / restoring divider for the |
// |           RV32M ops, BITS_PER_CYCLE bits retired per cycle.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module muldiv_unit
  import exe_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,   // accept a new op (caller guarantees idle)
  input  logic            abort,   // squash whatever is in flight
  input  logic            hold,    // keep DONE until downstream can take it
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,    // iterating
  output logic            done,    // result valid this cycle
  output logic [XLEN-1:0] result
);

  localparam int N_ITER = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  muldiv_state_e   state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] acc_hi, acc_lo;   // product hi/lo, or remainder/quotient
  logic [XLEN-1:0] opnd;             // multiplicand or divisor magnitude
  alu_op_e         op_q;
  logic            neg_q;            // negate product / quotient at the end
  logic            rem_neg_q;        // negate remainder at the end

  // Operand decode used only in the accept cycle
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_div   = op[2];
  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div && (b == '0);
  assign div_ovf  = is_div && b_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign special  = div_zero || div_ovf;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state: corner-case divides jump straight to DONE
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start) state_d = special ? S_DONE : (is_div ? S_DIV : S_MUL);
      S_MUL,
      S_DIV:  if (cnt == LAST_CNT) state_d = S_DONE;
      S_DONE: if (!hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // One iteration's worth of single-bit steps, unrolled BITS_PER_CYCLE times
  logic [XLEN-1:0] step_hi, step_lo, hi, lo;
  logic [XLEN:0]   shifted, diff, sum;
  always_comb begin
    hi      = acc_hi;
    lo      = acc_lo;
    shifted = '0;
    diff    = '0;
    sum     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (state == S_DIV) begin
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        if (!diff[XLEN]) begin
          hi = diff[XLEN-1:0];
          lo = {lo[XLEN-2:0], 1'b1};
        end else begin
          hi = shifted[XLEN-1:0];
          lo = {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        {hi, lo} = {sum, lo[XLEN-1:1]};
      end
    end
    step_hi = hi;
    step_lo = lo;
  end

  // Operand capture at accept, counter and accumulator update while iterating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      op_q      <= OP_ADD;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (state == S_IDLE && start) begin
      cnt  <= '0;
      op_q <= op;
      if (div_zero) begin
        // quotient all ones, remainder = dividend; no sign fix-up
        acc_hi    <= a;
        acc_lo    <= '1;
        neg_q     <= 1'b0;
        rem_neg_q <= 1'b0;
      end else if (div_ovf) begin
        acc_hi    <= '0;
        acc_lo    <= a;
        neg_q     <= 1'b0;
        rem_neg_q <= 1'b0;
      end else begin
        opnd      <= is_div ? b_mag : a_mag;
        acc_hi    <= '0;
        acc_lo    <= is_div ? a_mag : b_mag;
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
      end
    end else if (state == S_MUL || state == S_DIV) begin
      cnt    <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  // Sign correction and result selection, meaningful in DONE
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  always_comb begin
    prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_s  = neg_q ? -acc_lo : acc_lo;
    rem_s  = rem_neg_q ? -acc_hi : acc_hi;
    case (op_q)
      OP_MUL:                       result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_s;
      OP_REM, OP_REMU:              result = rem_s;
      default:                      result = '0;
    endcase
  end

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : exe_stage                                                  |
// | Brief   : RV32IM execute stage: single-cycle ALU, iterative mul/div, |
// |           EX/MEM pipeline register and upstream stall generation.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module exe_stage
  import exe_stage_pkg::*;
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  exe_stage_in_t exe_in,
  input  logic          valid_in,
  input  logic          flush,
  input  logic          stall_in,
  output logic          stall_out,
  output mem_stage_in_t mem_out,
  output logic          valid_out
);

  if (XLEN != 32) begin : g_xlen_check
    $error("exe_stage: only XLEN=32 is supported");
  end
  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bpc_check
    $error("exe_stage: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  logic            is_m, md_busy, md_done, md_idle, accept;
  logic [XLEN-1:0] md_result, alu_res;
  logic [4:0]      shamt;

  assign is_m    = is_muldiv(exe_in.alu_op);
  assign md_idle = !md_busy && !md_done;
  assign accept  = md_idle && valid_in && is_m && !flush;
  assign shamt   = exe_in.opr_b[4:0];

  // Hold upstream while an M op is accepted or running, while a finished
  // result waits for MEM, or while an ALU op cannot move into EX/MEM.
  assign stall_out = !rst && !flush &&
                     (md_busy || (md_done && stall_in) ||
                      (md_idle && valid_in && (is_m || stall_in)));

  muldiv_unit #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .abort  (flush),
    .hold   (stall_in),
    .op     (exe_in.alu_op),
    .a      (exe_in.opr_a),
    .b      (exe_in.opr_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle RV32I ALU
  always_comb begin
    alu_res = '0;
    case (exe_in.alu_op)
      OP_ADD:  alu_res = exe_in.opr_a + exe_in.opr_b;
      OP_SUB:  alu_res = exe_in.opr_a - exe_in.opr_b;
      OP_SLL:  alu_res = exe_in.opr_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(exe_in.opr_a) < $signed(exe_in.opr_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, exe_in.opr_a < exe_in.opr_b};
      OP_XOR:  alu_res = exe_in.opr_a ^ exe_in.opr_b;
      OP_SRL:  alu_res = exe_in.opr_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(exe_in.opr_a) >>> shamt);
      OP_OR:   alu_res = exe_in.opr_a | exe_in.opr_b;
      OP_AND:  alu_res = exe_in.opr_a & exe_in.opr_b;
      default: alu_res = '0;
    endcase
  end

  // Destination and control of the M op, captured when it is accepted
  logic [4:0]  md_rd;
  logic [31:0] md_store;
  logic        md_rf_en, md_dm_en;
  logic [1:0]  md_wb_sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_rd     <= '0;
      md_store  <= '0;
      md_rf_en  <= 1'b0;
      md_dm_en  <= 1'b0;
      md_wb_sel <= '0;
    end else if (accept) begin
      md_rd     <= exe_in.rd;
      md_store  <= exe_in.store_data;
      md_rf_en  <= exe_in.rf_en;
      md_dm_en  <= exe_in.dm_en;
      md_wb_sel <= exe_in.wb_sel;
    end
  end

  // EX/MEM register: flush, mul/div result, ALU result or bubble.
  // A flush while MEM stalls leaves the older instruction in EX/MEM intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_out   <= '0;
      valid_out <= 1'b0;
    end else if (!stall_in) begin
      if (flush) begin
        mem_out   <= '0;
        valid_out <= 1'b0;
      end else if (md_done) begin
        mem_out.rd      <= md_rd;
        mem_out.opr_b   <= md_store;
        mem_out.opr_res <= md_result;
        mem_out.rf_en   <= md_rf_en;
        mem_out.dm_en   <= md_dm_en;
        mem_out.wb_sel  <= md_wb_sel;
        valid_out       <= 1'b1;
      end else if (md_idle && valid_in && !is_m) begin
        mem_out.rd      <= exe_in.rd;
        mem_out.opr_b   <= exe_in.store_data;
        mem_out.opr_res <= alu_res;
        mem_out.rf_en   <= exe_in.rf_en;
        mem_out.dm_en   <= exe_in.dm_en;
        mem_out.wb_sel  <= exe_in.wb_sel;
        valid_out       <= 1'b1;
      end else begin
        mem_out   <= '0;
        valid_out <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_exe_stage                                               |
// | Brief   : Self-checking bench for exe_stage: vector table, scoreboard|
// |           and hand-written flush / stall / reset sequences.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_exe_stage;
  import exe_stage_pkg::*;
  import mem_stage_pkg::*;

  localparam int MD_STALLS = 33;  // accept cycle + 32 iteration cycles

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  exe_stage_in_t exe_in = '0;
  logic          valid_in = 1'b0;
  logic          flush = 1'b0;
  logic          stall_in = 1'b0;
  logic          stall_out;
  mem_stage_in_t mem_out;
  logic          valid_out;

  exe_stage #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .exe_in    (exe_in),
    .valid_in  (valid_in),
    .flush     (flush),
    .stall_in  (stall_in),
    .stall_out (stall_out),
    .mem_out   (mem_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] store;
  } exp_t;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          stalls;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  vec_t       vecs[23];
  int         checks = 0;
  int         failures = 0;
  logic [4:0] rd_ctr = 5'd1;
  logic       load_q = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exe_stage_in_t mk(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] rd);
    exe_stage_in_t t;
    t            = '0;
    t.alu_op     = op;
    t.opr_a      = a;
    t.opr_b      = b;
    t.rd         = rd;
    t.rf_en      = 1'b1;
    t.wb_sel     = 2'b01;
    t.store_data = a ^ b;
    return t;
  endfunction

  // Reference model computed with wide native arithmetic
  function automatic logic [31:0] model(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, ub, ps;
    logic [63:0] pu;
    int          ia, ib;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_SLL:    return a << b[4:0];
      OP_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:    return a ^ b;
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    return $unsigned($signed(a) >>> b[4:0]);
      OP_OR:     return a | b;
      OP_AND:    return a & b;
      OP_MUL:    begin ps = sa * sbv; return ps[31:0]; end
      OP_MULH:   begin ps = sa * sbv; return ps[63:32]; end
      OP_MULHSU: begin ps = sa * ub;  return ps[63:32]; end
      OP_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int exp_stalls(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (!op[4]) return 0;
    if (op[2] && b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return MD_STALLS;
  endfunction

  // Present one instruction, hold it until the stage consumes it, count stall cycles
  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int stalls);
    exp_t e;
    int   n;
    logic s;
    exe_in = mk(op, a, b, rd_ctr);
    e = '{rd_ctr, res, a ^ b};
    exp_q.push_back(e);
    rd_ctr = rd_ctr + 5'd1;
    valid_in = 1'b1;
    n = 0;
    forever begin
      #1;
      s = stall_out;
      @(posedge clk);
      if (!s) break;
      n++;
      if (n > 100) break;
    end
    chk($sformatf("stall_cycles_%s", op.name()), n, stalls);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Remember whether the EX/MEM register was allowed to load at each edge
  always @(posedge clk) load_q <= !stall_in;

  // Scoreboard: every newly loaded valid output must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && load_q && valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: actual res=%0h expected no output", mem_out.opr_res);
      end else begin
        mon_e = exp_q.pop_front();
        chk("opr_res", mem_out.opr_res, mon_e.res);
        chk("rd", mem_out.rd, mon_e.rd);
        chk("store", mem_out.opr_b, mon_e.store);
        chk("rf_en", mem_out.rf_en, 1'b1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0};
    vecs[1]  = '{OP_SUB,    32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0};
    vecs[2]  = '{OP_SLL,    32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 0};
    vecs[3]  = '{OP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0};
    vecs[4]  = '{OP_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0};
    vecs[5]  = '{OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0};
    vecs[6]  = '{OP_SRL,    32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 0};
    vecs[7]  = '{OP_SRA,    32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 0};
    vecs[8]  = '{OP_OR,     32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0};
    vecs[9]  = '{OP_AND,    32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 0};
    vecs[10] = '{OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, MD_STALLS};
    vecs[11] = '{OP_MUL,    32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, MD_STALLS};
    vecs[12] = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, MD_STALLS};
    vecs[13] = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, MD_STALLS};
    vecs[14] = '{OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[15] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[16] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[17] = '{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    vecs[18] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MD_STALLS};
    vecs[19] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MD_STALLS};
    vecs[20] = '{OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, MD_STALLS};
    vecs[21] = '{OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, MD_STALLS};
    vecs[22] = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_stall_out", stall_out, 1'b0);
    chk("rst_mem_out", mem_out, '0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table: ALU ops, M ops and divide corner cases
    for (int i = 0; i < 23; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].stalls);
    end
    repeat (2) @(negedge clk);
    chk("bubble_valid", valid_out, 1'b0);
    chk("bubble_rf_en", mem_out.rf_en, 1'b0);
    chk("bubble_dm_en", mem_out.dm_en, 1'b0);

    // Flush a DIVU at iteration 10
    exe_in = mk(OP_DIVU, 32'd100, 32'd7, 5'd30);
    valid_in = 1'b1;
    #1 chk("flush_accept_stall", stall_out, 1'b1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_stall_drop", stall_out, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush_bubble", valid_out, 1'b0);
    chk("flush_bubble_rf", mem_out.rf_en, 1'b0);
    issue(OP_ADD, 32'd3, 32'd4, 32'd7, 0);
    chk("post_flush_add_valid", valid_out, 1'b1);
    repeat (2) @(negedge clk);

    // MULHU with stall_in covering the DONE cycle
    exe_in = mk(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd_ctr);
    mon_e = '{rd_ctr, 32'hFFFF_FFFE, 32'h0};
    exp_q.push_back(mon_e);
    rd_ctr = rd_ctr + 5'd1;
    valid_in = 1'b1;
    repeat (30) @(negedge clk);
    stall_in = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("done_hold_stall", stall_out, 1'b1);
    chk("done_hold_no_load", valid_out, 1'b0);
    stall_in = 1'b0;
    #1 chk("done_release_stall", stall_out, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    chk("done_loaded_valid", valid_out, 1'b1);
    stall_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_res", mem_out.opr_res, 32'hFFFF_FFFE);
    chk("held_valid", valid_out, 1'b1);
    stall_in = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a DIV while EX/MEM holds an ADD
    issue(OP_ADD, 32'h11, 32'h22, 32'h33, 0);
    stall_in = 1'b1;
    exe_in = mk(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd31);
    valid_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_held", valid_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", valid_out, 1'b0);
    chk("rst_async_mem", mem_out, '0);
    chk("rst_async_stall", stall_out, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    stall_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Random mix checked against the reference model
    for (int i = 0; i < 40; i++) begin
      int          code, sel;
      alu_op_e     op;
      logic [31:0] a, b;
      code = $urandom_range(0, 17);
      op   = alu_op_e'(5'((code < 10) ? code : code + 6));
      sel  = $urandom_range(0, 7);
      a    = $urandom;
      b    = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = b & 32'h0000_00FF;
      issue(op, a, b, model(op, a, b), exp_stalls(op, a, b));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
